contador_ms_bcd: RTL and testbench
==================================

# contador_ms_bcd

- Millisecond stopwatch core; sits directly downstream of the frequency divider.
- Consumes the divider's 1 ms square wave (CLK_U, period 100 000 CLK cycles) as a tick source.
- Counts elapsed milliseconds as four BCD digits (0000–9999 ms), under start/stop and clear control.
- Digit outputs feed the display stage; everything runs in the single CLK domain.

## Interface
Parameters:
- MAX_BCD, 16'h9999, terminal count in packed BCD; count saturates here.

Ports:
- CLK  in  1  system clock; same clock that drives the divider.
- RESET  in  1  asynchronous, active-low reset (0 = reset asserted).
- TICK_MS  in  1  1 ms square wave from the divider (CLK_U); each rising edge is one millisecond.
- START_STOP  in  1  debounced button level; each rising edge toggles run/pause.
- CLEAR  in  1  synchronous clear, level-sensitive, active-high.
- DIG0  out  4  BCD units of ms.
- DIG1  out  4  BCD tens of ms.
- DIG2  out  4  BCD hundreds of ms.
- DIG3  out  4  BCD thousands of ms.
- RUNNING  out  1  high while in RUN.
- OVF  out  1  high while in FULL (count saturated at 9999).

## Operation
- Edge detect, registered: tick = TICK_MS & ~tick_q; press = START_STOP & ~ss_q.
- On reset, tick_q resets to 0 and ss_q resets to 1, so a button held through reset release does not start the count.
- States:
  - IDLE: count 0000, stopped.
  - RUN: counting.
  - PAUSE: stopped, count retained.
  - FULL: saturated at 9999.
- Priority within a cycle: CLEAR > tick > press.
- CLEAR = 1 in any state: digits → 0000, OVF → 0, next state IDLE. Tick and press are ignored that cycle.
- IDLE: press → RUN. A tick in the same cycle is not counted.
- RUN:
  - tick with count < 9999 → BCD increment.
  - tick with count = 9999 → count stays 9999, next state FULL.
  - press → PAUSE. If tick and press coincide, the tick is counted first, then the block pauses.
- PAUSE: press → RUN (a tick in the same cycle is not counted). Ticks are ignored.
- FULL: press and tick ignored; only CLEAR or RESET exits.
- BCD increment rules:
  - DIG0 9→0 carries into DIG1; DIG1 9→0 carries into DIG2; DIG2 9→0 carries into DIG3.
  - No digit ever holds a value above 9.
  - The count never wraps to 0000.
- RUNNING = (state == RUN); OVF = (state == FULL). Both are registered, decoded from the state register.

## Timing
- Reset (RESET = 0, asynchronous):
  - DIG0–DIG3 = 0, RUNNING = 0, OVF = 0, state IDLE.
  - tick_q = 0, ss_q = 1.
  - Release is synchronous to the next CLK edge; the system synchronizer guarantees this.
- Tick latency: TICK_MS is first sampled high at edge k; the incremented digits are visible after edge k (one-cycle latency).
- One increment per TICK_MS rising edge, regardless of how long TICK_MS stays high.
- START_STOP latency: press sampled at edge k → RUNNING changes after edge k.
- FULL entry: the 10 000th counted tick sets OVF after the same edge; the digits remain 9,9,9,9.
- CLEAR latency: sampled at edge k → outputs zero after edge k.
- Reset mid-count: asynchronous clear of all outputs; no partial digit update survives.
- Inputs TICK_MS, START_STOP and CLEAR are synchronous to CLK. The block contains no synchronizers.

## Test plan
- Reset: hold RESET = 0 with START_STOP = 1, then release with START_STOP held → digits 0000, RUNNING = 0, OVF = 0. No start until START_STOP goes 0 and then 1.
- Basic count: press, then 123 TICK_MS rising edges, each pulse high 3 cycles → DIG3..DIG0 = 0,1,2,3 and RUNNING = 1. Each increment appears one cycle after the TICK_MS rise.
- Carry chain: run to 0999, one more tick → 1000.
- Pause/resume: pause at 0042, then 5 ticks → still 0042. Press again, 1 tick → 0043.
- Coincident events:
  - Tick and press in the same cycle while in RUN at 0010 → 0011 and PAUSE.
  - Same coincidence in PAUSE → no increment, RUNNING = 1.
- Saturation and clear:
  - Run to 9999, one more tick → 9999 and OVF = 1.
  - Further ticks and presses → unchanged.
  - CLEAR = 1 for one cycle, coincident with a tick → 0000, OVF = 0, IDLE.

Source files
------------

// File: rtl/contador_ms_bcd.sv
// rtl/contador_ms_bcd.sv - millisecond stopwatch core, four BCD digits with run/pause/clear
//
// Purpose: counts rising edges of the 1 ms tick from the frequency divider as
// a four-digit BCD value (0000-9999), saturating at MAX_BCD.
//
// Ports:
//   CLK         in   system clock (shared with the divider)
//   RESET       in   asynchronous active-low reset
//   TICK_MS     in   1 ms square wave; each rising edge is one millisecond
//   START_STOP  in   debounced button level; each rising edge toggles run/pause
//   CLEAR       in   synchronous level-sensitive clear, active-high
//   DIG0..DIG3  out  BCD units / tens / hundreds / thousands of ms
//   RUNNING     out  high while counting
//   OVF         out  high while saturated at MAX_BCD
module contador_ms_bcd #(
  parameter logic [15:0] MAX_BCD = 16'h9999
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK_MS,
  input  logic       START_STOP,
  input  logic       CLEAR,
  output logic [3:0] DIG0,
  output logic [3:0] DIG1,
  output logic [3:0] DIG2,
  output logic [3:0] DIG3,
  output logic       RUNNING,
  output logic       OVF
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_FULL  = 2'd3;

  logic [1:0] r_state;
  logic       r_tick_q;
  logic       r_ss_q;
  logic [3:0] r_dig0;
  logic [3:0] r_dig1;
  logic [3:0] r_dig2;
  logic [3:0] r_dig3;

  logic       w_tick;
  logic       w_press;
  logic       w_at_max;
  logic       w_c0;
  logic       w_c1;
  logic       w_c2;
  logic [3:0] w_n0;
  logic [3:0] w_n1;
  logic [3:0] w_n2;
  logic [3:0] w_n3;

  assign w_tick   = TICK_MS & ~r_tick_q;
  assign w_press  = START_STOP & ~r_ss_q;
  assign w_at_max = ({r_dig3, r_dig2, r_dig1, r_dig0} == MAX_BCD);

  // Ripple BCD increment; the top digit never needs a carry-out because the
  // increment is suppressed once the count reaches MAX_BCD.
  assign w_c0 = (r_dig0 == 4'd9);
  assign w_c1 = w_c0 & (r_dig1 == 4'd9);
  assign w_c2 = w_c1 & (r_dig2 == 4'd9);
  assign w_n0 = w_c0 ? 4'd0 : r_dig0 + 4'd1;
  assign w_n1 = w_c0 ? ((r_dig1 == 4'd9) ? 4'd0 : r_dig1 + 4'd1) : r_dig1;
  assign w_n2 = w_c1 ? ((r_dig2 == 4'd9) ? 4'd0 : r_dig2 + 4'd1) : r_dig2;
  assign w_n3 = w_c2 ? ((r_dig3 == 4'd9) ? 4'd0 : r_dig3 + 4'd1) : r_dig3;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= S_IDLE;
      r_tick_q <= 1'b0;
      // Reset high so a button held through reset release is not a press.
      r_ss_q   <= 1'b1;
      r_dig0   <= 4'd0;
      r_dig1   <= 4'd0;
      r_dig2   <= 4'd0;
      r_dig3   <= 4'd0;
    end else begin
      r_tick_q <= TICK_MS;
      r_ss_q   <= START_STOP;
      if (CLEAR) begin
        r_state <= S_IDLE;
        r_dig0  <= 4'd0;
        r_dig1  <= 4'd0;
        r_dig2  <= 4'd0;
        r_dig3  <= 4'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_press) r_state <= S_RUN;
          end
          S_RUN: begin
            if (w_tick && !w_at_max) begin
              r_dig0 <= w_n0;
              r_dig1 <= w_n1;
              r_dig2 <= w_n2;
              r_dig3 <= w_n3;
            end
            // Saturation wins over a coincident press: FULL only exits on clear.
            if (w_tick && w_at_max) r_state <= S_FULL;
            else if (w_press)       r_state <= S_PAUSE;
          end
          S_PAUSE: begin
            if (w_press) r_state <= S_RUN;
          end
          default: begin
            r_state <= S_FULL;
          end
        endcase
      end
    end
  end

  assign DIG0    = r_dig0;
  assign DIG1    = r_dig1;
  assign DIG2    = r_dig2;
  assign DIG3    = r_dig3;
  assign RUNNING = (r_state == S_RUN);
  assign OVF     = (r_state == S_FULL);

endmodule

// File: tb/tb_contador_ms_bcd.sv
// tb/tb_contador_ms_bcd.sv - scoreboard bench for contador_ms_bcd
module tb_contador_ms_bcd;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       TICK_MS;
  logic       START_STOP;
  logic       CLEAR;
  logic [3:0] DIG0;
  logic [3:0] DIG1;
  logic [3:0] DIG2;
  logic [3:0] DIG3;
  logic       RUNNING;
  logic       OVF;

  contador_ms_bcd #(.MAX_BCD(16'h9999)) dut (
    .CLK(CLK), .RESET(RESET), .TICK_MS(TICK_MS), .START_STOP(START_STOP),
    .CLEAR(CLEAR), .DIG0(DIG0), .DIG1(DIG1), .DIG2(DIG2), .DIG3(DIG3),
    .RUNNING(RUNNING), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [15:0] dig;
    logic        run;
    logic        ovf;
    string       name;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] bcd(input int v);
    bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Expectation for the outputs seen after the next rising edge.
  task automatic expect_next(input string nm, input int v, input logic r, input logic o);
    exp_t e;
    e.at = cyc + 1; e.dig = bcd(v); e.run = r; e.ovf = o; e.name = nm;
    q.push_back(e);
  endtask

  task automatic cyc_in(input logic t, input logic s, input logic c);
    TICK_MS = t; START_STOP = s; CLEAR = c;
    @(posedge CLK);
    #1;
  endtask

  task automatic tick(input int hi, input int lo, input bit chk, input string nm,
                      input int v, input logic r, input logic o);
    for (int i = 0; i < hi; i++) begin
      if (chk) expect_next(nm, v, r, o);
      cyc_in(1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < lo; i++) cyc_in(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press(input string nm, input int v, input logic r);
    expect_next(nm, v, r, 1'b0);
    cyc_in(1'b0, 1'b1, 1'b0);
    cyc_in(1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_now();
    expect_next("clear", 0, 1'b0, 1'b0);
    cyc_in(1'b0, 1'b0, 1'b1);
    cyc_in(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares DUT outputs against the queued expectation for this cycle.
  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (e.at != cyc) begin
        bad++;
        $display("FAIL %s: checked late at cycle %0d, required cycle %0d", e.name, cyc, e.at);
      end else if ({DIG3, DIG2, DIG1, DIG0} !== e.dig || RUNNING !== e.run || OVF !== e.ovf) begin
        bad++;
        $display("FAIL %s: got dig=%h run=%b ovf=%b, required dig=%h run=%b ovf=%b",
                 e.name, {DIG3, DIG2, DIG1, DIG0}, RUNNING, OVF, e.dig, e.run, e.ovf);
      end
    end
  end

  initial begin
    RESET = 1'b0; TICK_MS = 1'b0; START_STOP = 1'b1; CLEAR = 1'b0;
    #1;
    expect_next("rst_hold", 0, 1'b0, 1'b0);
    cyc_in(1'b0, 1'b1, 1'b0);
    cyc_in(1'b0, 1'b1, 1'b0);
    RESET = 1'b1;
    expect_next("rst_release_ss_held", 0, 1'b0, 1'b0);
    cyc_in(1'b0, 1'b1, 1'b0);
    expect_next("idle_held_tick", 0, 1'b0, 1'b0);
    cyc_in(1'b1, 1'b1, 1'b0);
    cyc_in(1'b0, 1'b0, 1'b0);

    // IDLE: press with a coincident tick starts but does not count.
    expect_next("idle_press_tick", 0, 1'b1, 1'b0);
    cyc_in(1'b1, 1'b1, 1'b0);
    cyc_in(1'b0, 1'b0, 1'b0);

    // Basic count with 3-cycle-wide tick pulses.
    for (int v = 1; v <= 123; v++)
      tick(3, 2, (v <= 3) || (v == 123), "basic_count", v, 1'b1, 1'b0);

    // Carry chain 0999 -> 1000.
    for (int v = 124; v <= 999; v++)
      tick(1, 1, v == 999, "count_999", v, 1'b1, 1'b0);
    tick(1, 1, 1'b1, "carry_1000", 1000, 1'b1, 1'b0);

    // Pause / resume.
    clear_now();
    press("start_pr", 0, 1'b1);
    for (int v = 1; v <= 42; v++)
      tick(1, 1, v == 42, "count_42", v, 1'b1, 1'b0);
    press("pause_42", 42, 1'b0);
    for (int i = 0; i < 5; i++) tick(1, 1, 1'b1, "paused_tick", 42, 1'b0, 1'b0);
    press("resume_42", 42, 1'b1);
    tick(1, 1, 1'b1, "resume_tick", 43, 1'b1, 1'b0);

    // Coincident tick and press.
    clear_now();
    press("start_co", 0, 1'b1);
    for (int v = 1; v <= 10; v++) tick(1, 1, v == 10, "count_10", v, 1'b1, 1'b0);
    expect_next("coinc_run", 11, 1'b0, 1'b0);
    cyc_in(1'b1, 1'b1, 1'b0);
    cyc_in(1'b0, 1'b0, 1'b0);
    expect_next("coinc_pause", 11, 1'b1, 1'b0);
    cyc_in(1'b1, 1'b1, 1'b0);
    cyc_in(1'b0, 1'b0, 1'b0);
    tick(1, 1, 1'b1, "after_coinc", 12, 1'b1, 1'b0);

    // Saturation at 9999.
    clear_now();
    press("start_sat", 0, 1'b1);
    for (int v = 1; v <= 9999; v++)
      tick(1, 1, (v == 9998) || (v == 9999), "count_9999", v, 1'b1, 1'b0);
    tick(1, 1, 1'b1, "full_entry", 9999, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1, 1, 1'b1, "full_tick", 9999, 1'b0, 1'b1);
    expect_next("full_press", 9999, 1'b0, 1'b1);
    cyc_in(1'b0, 1'b1, 1'b0);
    cyc_in(1'b0, 1'b0, 1'b0);
    expect_next("clear_with_tick", 0, 1'b0, 1'b0);
    cyc_in(1'b1, 1'b0, 1'b1);
    cyc_in(1'b0, 1'b0, 1'b0);
    tick(1, 1, 1'b1, "idle_after_clear", 0, 1'b0, 1'b0);

    // Reset in the middle of a count.
    press("start_rst", 0, 1'b1);
    for (int v = 1; v <= 7; v++) tick(1, 1, v == 7, "count_7", v, 1'b1, 1'b0);
    RESET = 1'b0;
    expect_next("rst_mid", 0, 1'b0, 1'b0);
    cyc_in(1'b1, 1'b0, 1'b0);
    RESET = 1'b1;
    cyc_in(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    @(negedge CLK);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
